// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Runs one FFT frame through an FFT core wrapper. On an accepted start it
//   writes the latched config word, streams NFFT samples from the upstream
//   sample FIFO to the core (tlast on the final beat), and then drains NFFT
//   results towards the downstream result FIFO, counting them and flagging
//   framing errors.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start, cfg_word             frame request and the config word captured with it
//   src_tvalid/tdata/tready     sample FIFO side (tready pops the FIFO)
//   s_axis_config_*             config channel to the FFT core
//   s_axis_data_*               sample stream to the FFT core
//   m_axis_data_tvalid/tlast/   result stream from the FFT core
//   m_axis_data_tready
//   sink_ready                  downstream result FIFO has room
//   busy                        high in every state except IDLE
//   done                        one-cycle pulse at end of frame
//   frame_err                   [0] early result tlast, [1] missing result tlast,
//                               [2] drain timeout; held until the next accepted start
module fft_frame_sequencer #(
  parameter int NFFT    = 512,
  parameter int CNT_W   = 9,
  parameter int CFG_W   = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg_word,
  input  logic              src_tvalid,
  input  logic [DATA_W-1:0] src_tdata,
  output logic              src_tready,
  output logic              s_axis_config_tvalid,
  output logic [CFG_W-1:0]  s_axis_config_tdata,
  input  logic              s_axis_config_tready,
  output logic              s_axis_data_tvalid,
  output logic [DATA_W-1:0] s_axis_data_tdata,
  output logic              s_axis_data_tlast,
  input  logic              s_axis_data_tready,
  input  logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tlast,
  output logic              m_axis_data_tready,
  input  logic              sink_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        frame_err
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NFFT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [2:0]        err_q, err_d;
  logic              in_beat, out_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      timer_q   <= '0;
      cfg_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      timer_q   <= timer_d;
      cfg_q     <= cfg_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    in_cnt_d             = in_cnt_q;
    out_cnt_d            = out_cnt_q;
    timer_d              = timer_q;
    cfg_d                = cfg_q;
    err_d                = err_q;
    in_beat              = 1'b0;
    out_beat             = 1'b0;
    src_tready           = 1'b0;
    s_axis_config_tvalid = 1'b0;
    s_axis_data_tvalid   = 1'b0;
    s_axis_data_tlast    = 1'b0;
    m_axis_data_tready   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d     = cfg_word;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          timer_d   = '0;
          err_d     = '0;
          state_d   = S_CONFIG;
        end
      end

      S_CONFIG: begin
        s_axis_config_tvalid = 1'b1;
        if (s_axis_config_tready) state_d = S_LOAD;
      end

      // Zero-latency pass-through: the core's ready pops the FIFO directly.
      S_LOAD: begin
        s_axis_data_tvalid = src_tvalid;
        src_tready         = s_axis_data_tready;
        s_axis_data_tlast  = (in_cnt_q == LAST_BEAT);
        in_beat            = src_tvalid & s_axis_data_tready;
        if (in_beat) begin
          if (in_cnt_q == LAST_BEAT) state_d = S_DRAIN;
          else                       in_cnt_d = in_cnt_q + 1'b1;
        end
      end

      // A beat always clears the timer, so a beat landing on the expiry
      // cycle takes precedence over the timeout.
      S_DRAIN: begin
        m_axis_data_tready = sink_ready;
        out_beat           = m_axis_data_tvalid & sink_ready;
        if (out_beat) begin
          timer_d = '0;
          if (out_cnt_q != LAST_BEAT) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (m_axis_data_tlast) begin
              err_d[0] = 1'b1;
              state_d  = S_DONE;
            end
          end else begin
            if (!m_axis_data_tlast) err_d[1] = 1'b1;
            state_d = S_DONE;
          end
        end else if (timer_q == TMR_MAX) begin
          err_d[2] = 1'b1;
          state_d  = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign s_axis_config_tdata = cfg_q;
  assign s_axis_data_tdata   = src_tdata;
  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE);
  assign frame_err           = err_q;

endmodule
